// File: rtl/doom_pkg.sv
// -----------------------------------------------------------------------------
// doom_pkg
// Shared types and helpers for the player motion path.
//   heading_t      : 2-bit compass heading (N/E/S/W)
//   state_t        : motion FSM state
//   HEAD_DX/HEAD_DY: per-heading one-cell step, indexed by heading
//   rot_cw/rot_ccw : +90 / -90 degree rotation with mod-4 wrap
// -----------------------------------------------------------------------------
package doom_pkg;

  typedef enum logic [1:0] {
    HEAD_N = 2'd0,
    HEAD_E = 2'd1,
    HEAD_S = 2'd2,
    HEAD_W = 2'd3
  } heading_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUERY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Screen-style coordinates: north decreases Y.
  localparam int HEAD_DX [4] = '{0, 1, 0, -1};
  localparam int HEAD_DY [4] = '{-1, 0, 1, 0};

  function automatic heading_t rot_cw(input heading_t h);
    return heading_t'(h + 2'd1);
  endfunction

  function automatic heading_t rot_ccw(input heading_t h);
    return heading_t'(h - 2'd1);
  endfunction

endpackage

// File: rtl/press_sync_edge.sv
// -----------------------------------------------------------------------------
// press_sync_edge
// Two-flop synchronizer followed by a rising-edge detector for one button
// level. Holding the button produces a single o_rise cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_level    : raw button level, asynchronous to clk
//   o_rise     : high for one cycle after the synchronized level rises
// -----------------------------------------------------------------------------
module press_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_level;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Turns button presses into player actions (turn -90/+90, step forward) and
// owns the player's grid position and heading. Forward steps are checked for
// walls through a req/ack query to the map store before being committed.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rotateN90_press            : turn-left button level (async)
//   forward_press              : forward button level (async)
//   rotate90_press             : turn-right button level (async)
//   map_req / map_addr         : wall query, held until map_ack
//   map_ack / map_wall         : query response strobe and wall flag
//   pos_x, pos_y, heading      : authoritative player state
//   busy                       : an action is in flight
//   turned, moved, bumped      : one-cycle completion pulses
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module player_motion_ctrl
  import doom_pkg::*;
#(
  parameter int MAP_W      = 16,
  parameter int MAP_H      = 16,
  parameter int START_X    = 1,
  parameter int START_Y    = 1,
  parameter int START_HEAD = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rotateN90_press,
  input  logic                             forward_press,
  input  logic                             rotate90_press,
  output logic                             map_req,
  output logic [$clog2(MAP_W*MAP_H)-1:0]   map_addr,
  input  logic                             map_ack,
  input  logic                             map_wall,
  output logic [$clog2(MAP_W)-1:0]         pos_x,
  output logic [$clog2(MAP_H)-1:0]         pos_y,
  output logic [1:0]                       heading,
  output logic                             busy,
  output logic                             turned,
  output logic                             moved,
  output logic                             bumped
);

  localparam int X_W    = $clog2(MAP_W);
  localparam int Y_W    = $clog2(MAP_H);
  localparam int ADDR_W = $clog2(MAP_W*MAP_H);

  // ---------------------------------------------------------------------------
  // Press conditioning
  // ---------------------------------------------------------------------------
  logic w_ccw_rise;
  logic w_fwd_rise;
  logic w_cw_rise;

  press_sync_edge u_sync_ccw (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (rotateN90_press),
    .o_rise  (w_ccw_rise)
  );

  press_sync_edge u_sync_fwd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (forward_press),
    .o_rise  (w_fwd_rise)
  );

  press_sync_edge u_sync_cw (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (rotate90_press),
    .o_rise  (w_cw_rise)
  );

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  heading_t          r_heading;
  logic [X_W-1:0]    r_pos_x;
  logic [Y_W-1:0]    r_pos_y;
  logic [X_W-1:0]    r_tgt_x;
  logic [Y_W-1:0]    r_tgt_y;
  logic              r_map_req;
  logic [ADDR_W-1:0] r_map_addr;
  logic              r_busy;
  logic              r_turned;
  logic              r_moved;
  logic              r_bumped;

  state_t            w_state_nxt;
  heading_t          w_heading_nxt;
  logic [X_W-1:0]    w_pos_x_nxt;
  logic [Y_W-1:0]    w_pos_y_nxt;
  logic [X_W-1:0]    w_tgt_x_nxt;
  logic [Y_W-1:0]    w_tgt_y_nxt;
  logic              w_map_req_nxt;
  logic [ADDR_W-1:0] w_map_addr_nxt;
  logic              w_turned_nxt;
  logic              w_moved_nxt;
  logic              w_bumped_nxt;

  // Signed target so stepping off either edge is a plain range check.
  int                w_tx;
  int                w_ty;
  logic              w_oob;

  // ---------------------------------------------------------------------------
  // Next-state / output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default before the case statement; any path
  // that left one unassigned would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_heading_nxt  = r_heading;
    w_pos_x_nxt    = r_pos_x;
    w_pos_y_nxt    = r_pos_y;
    w_tgt_x_nxt    = r_tgt_x;
    w_tgt_y_nxt    = r_tgt_y;
    w_map_req_nxt  = r_map_req;
    w_map_addr_nxt = r_map_addr;
    w_turned_nxt   = 1'b0;
    w_moved_nxt    = 1'b0;
    w_bumped_nxt   = 1'b0;

    w_tx  = int'(r_pos_x) + HEAD_DX[r_heading];
    w_ty  = int'(r_pos_y) + HEAD_DY[r_heading];
    w_oob = (w_tx < 0) || (w_tx >= MAP_W) || (w_ty < 0) || (w_ty >= MAP_H);

    unique case (r_state)
      ST_IDLE: begin
        // Forward outranks turns; turn edges coinciding with it are dropped.
        if (w_fwd_rise) begin
          if (w_oob) begin
            w_bumped_nxt = 1'b1;
          end else begin
            w_state_nxt    = ST_QUERY;
            w_map_req_nxt  = 1'b1;
            w_tgt_x_nxt    = X_W'(w_tx);
            w_tgt_y_nxt    = Y_W'(w_ty);
            w_map_addr_nxt = ADDR_W'(w_ty * MAP_W + w_tx);
          end
        end else if (w_cw_rise && !w_ccw_rise) begin
          w_heading_nxt = rot_cw(r_heading);
          w_turned_nxt  = 1'b1;
        end else if (w_ccw_rise && !w_cw_rise) begin
          w_heading_nxt = rot_ccw(r_heading);
          w_turned_nxt  = 1'b1;
        end
      end

      ST_QUERY: begin
        if (map_ack) begin
          w_map_req_nxt = 1'b0;
          if (map_wall) begin
            w_bumped_nxt = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_state_nxt  = ST_COMMIT;
          end
        end
      end

      ST_COMMIT: begin
        w_pos_x_nxt = r_tgt_x;
        w_pos_y_nxt = r_tgt_y;
        w_moved_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_map_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_heading  <= heading_t'(2'(START_HEAD));
      r_pos_x    <= X_W'(START_X);
      r_pos_y    <= Y_W'(START_Y);
      r_tgt_x    <= '0;
      r_tgt_y    <= '0;
      r_map_req  <= 1'b0;
      r_map_addr <= '0;
      r_busy     <= 1'b0;
      r_turned   <= 1'b0;
      r_moved    <= 1'b0;
      r_bumped   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_heading  <= w_heading_nxt;
      r_pos_x    <= w_pos_x_nxt;
      r_pos_y    <= w_pos_y_nxt;
      r_tgt_x    <= w_tgt_x_nxt;
      r_tgt_y    <= w_tgt_y_nxt;
      r_map_req  <= w_map_req_nxt;
      r_map_addr <= w_map_addr_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_turned   <= w_turned_nxt;
      r_moved    <= w_moved_nxt;
      r_bumped   <= w_bumped_nxt;
    end
  end

  assign map_req  = r_map_req;
  assign map_addr = r_map_addr;
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign heading  = r_heading;
  assign busy     = r_busy;
  assign turned   = r_turned;
  assign moved    = r_moved;
  assign bumped   = r_bumped;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_motion_ctrl
// Directed bench for player_motion_ctrl on a 16x16 map starting at (1,1)
// facing north. Inputs change 1 ns after a rising edge; outputs are read at
// the same point, so each read reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rotateN90_press;
  logic       forward_press;
  logic       rotate90_press;
  logic       map_req;
  logic [7:0] map_addr;
  logic       map_ack;
  logic       map_wall;
  logic [3:0] pos_x;
  logic [3:0] pos_y;
  logic [1:0] heading;
  logic       busy;
  logic       turned;
  logic       moved;
  logic       bumped;

  int checks = 0;
  int errors = 0;

  // Monotonic pulse counters; scenarios compare against a snapshot.
  int n_turned = 0;
  int n_moved  = 0;
  int n_bumped = 0;
  int n_req    = 0;

  player_motion_ctrl #(
    .MAP_W      (16),
    .MAP_H      (16),
    .START_X    (1),
    .START_Y    (1),
    .START_HEAD (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rotateN90_press (rotateN90_press),
    .forward_press   (forward_press),
    .rotate90_press  (rotate90_press),
    .map_req         (map_req),
    .map_addr        (map_addr),
    .map_ack         (map_ack),
    .map_wall        (map_wall),
    .pos_x           (pos_x),
    .pos_y           (pos_y),
    .heading         (heading),
    .busy            (busy),
    .turned          (turned),
    .moved           (moved),
    .bumped          (bumped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (turned)  n_turned++;
    if (moved)   n_moved++;
    if (bumped)  n_bumped++;
    if (map_req) n_req++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // b: 0 = rotateN90, 1 = forward, 2 = rotate90
  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       rotateN90_press = v;
      1:       forward_press   = v;
      default: rotate90_press  = v;
    endcase
  endtask

  task automatic turn_once(input int b);
    set_btn(b, 1'b1);
    ticks(4);
    set_btn(b, 1'b0);
    ticks(4);
  endtask

  // Forward step with a free target; ack lands on the second QUERY cycle.
  task automatic move_free(input logic [7:0] exp_addr, input logic [3:0] ex,
                           input logic [3:0] ey);
    forward_press = 1'b1;
    ticks(3);
    checks++;
    if (map_req !== 1'b1 || map_addr !== exp_addr) begin
      errors++;
      $display("FAIL move_free_req: req=%b addr=%0d, expected req=1 addr=%0d",
               map_req, map_addr, exp_addr);
    end
    tick();
    map_ack = 1'b1; map_wall = 1'b0;
    tick();
    map_ack = 1'b0;
    tick();
    forward_press = 1'b0;
    checks++;
    if (pos_x !== ex || pos_y !== ey || moved !== 1'b1) begin
      errors++;
      $display("FAIL move_free_pos: pos=(%0d,%0d) moved=%b, expected (%0d,%0d) moved=1",
               pos_x, pos_y, moved, ex, ey);
    end
    ticks(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rotateN90_press = 1'b0; forward_press = 1'b0; rotate90_press = 1'b0;
    map_ack = 1'b0; map_wall = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    checks++;
    if (pos_x !== 4'd1 || pos_y !== 4'd1 || heading !== 2'd0) begin
      errors++;
      $display("FAIL reset_pos: pos=(%0d,%0d) head=%0d, expected (1,1) head=0",
               pos_x, pos_y, heading);
    end
    checks++;
    if (busy !== 1'b0 || map_req !== 1'b0 || map_addr !== 8'd0 ||
        turned !== 1'b0 || moved !== 1'b0 || bumped !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b req=%b addr=%0d pulses=%b%b%b, expected all 0",
               busy, map_req, map_addr, turned, moved, bumped);
    end
  endtask

  task automatic test_turn();
    int base;
    base = n_turned;
    rotate90_press = 1'b1;        // rises just after edge k
    ticks(2);                      // edge k+2
    checks++;
    if (heading !== 2'd0 || turned !== 1'b0) begin
      errors++;
      $display("FAIL turn_early: head=%0d turned=%b at k+2, expected head=0 turned=0",
               heading, turned);
    end
    tick();                        // edge k+3
    checks++;
    if (heading !== 2'd1 || turned !== 1'b1) begin
      errors++;
      $display("FAIL turn_k3: head=%0d turned=%b at k+3, expected head=1 turned=1",
               heading, turned);
    end
    ticks(17);
    rotate90_press = 1'b0;
    ticks(4);
    checks++;
    if (n_turned - base !== 1 || heading !== 2'd1) begin
      errors++;
      $display("FAIL turn_hold: pulses=%0d head=%0d, expected pulses=1 head=1",
               n_turned - base, heading);
    end
    for (int i = 0; i < 3; i++) turn_once(2);
    checks++;
    if (heading !== 2'd0 || n_turned - base !== 4) begin
      errors++;
      $display("FAIL turn_wrap: head=%0d pulses=%0d, expected head=0 pulses=4",
               heading, n_turned - base);
    end
    turn_once(0);
    checks++;
    if (heading !== 2'd3) begin
      errors++;
      $display("FAIL turn_ccw: head=%0d, expected 3", heading);
    end
    turn_once(2);                  // W -> N
    turn_once(2);                  // N -> E
  endtask

  task automatic test_move_free();
    int base;
    base = n_moved;
    move_free(8'd18, 4'd2, 4'd1);
    checks++;
    if (n_moved - base !== 1 || busy !== 1'b0 || map_req !== 1'b0) begin
      errors++;
      $display("FAIL move_once: pulses=%0d busy=%b req=%b, expected 1/0/0",
               n_moved - base, busy, map_req);
    end
  endtask

  task automatic test_move_wall();
    int base;
    base = n_bumped;
    forward_press = 1'b1;
    ticks(3);
    checks++;
    if (map_req !== 1'b1 || map_addr !== 8'd19 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wall_req: req=%b addr=%0d busy=%b, expected 1/19/1",
               map_req, map_addr, busy);
    end
    tick();
    map_ack = 1'b1; map_wall = 1'b1;
    tick();                        // edge m
    map_ack = 1'b0; map_wall = 1'b0;
    checks++;
    if (bumped !== 1'b1 || map_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wall_ack: bumped=%b req=%b busy=%b, expected 1/0/0",
               bumped, map_req, busy);
    end
    forward_press = 1'b0;
    ticks(4);
    checks++;
    if (pos_x !== 4'd2 || pos_y !== 4'd1 || n_bumped - base !== 1 || map_req !== 1'b0) begin
      errors++;
      $display("FAIL wall_after: pos=(%0d,%0d) bumps=%0d req=%b, expected (2,1) 1 0",
               pos_x, pos_y, n_bumped - base, map_req);
    end
  endtask

  task automatic test_oob_and_dual_turn();
    int base_b;
    int base_r;
    int base_t;
    turn_once(2); turn_once(2);    // E -> S -> W
    move_free(8'd17, 4'd1, 4'd1);
    turn_once(2);                  // W -> N
    move_free(8'd1, 4'd1, 4'd0);
    base_b = n_bumped;
    base_r = n_req;
    forward_press = 1'b1;
    ticks(2);
    checks++;
    if (bumped !== 1'b0) begin
      errors++;
      $display("FAIL oob_early: bumped=%b at k+2, expected 0", bumped);
    end
    tick();
    checks++;
    if (bumped !== 1'b1 || map_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oob_k3: bumped=%b req=%b busy=%b, expected 1/0/0",
               bumped, map_req, busy);
    end
    forward_press = 1'b0;
    ticks(4);
    checks++;
    if (n_req - base_r !== 0 || n_bumped - base_b !== 1 || pos_y !== 4'd0) begin
      errors++;
      $display("FAIL oob_after: req_cycles=%0d bumps=%0d y=%0d, expected 0 1 0",
               n_req - base_r, n_bumped - base_b, pos_y);
    end
    base_t = n_turned;
    rotate90_press = 1'b1; rotateN90_press = 1'b1;
    ticks(5);
    rotate90_press = 1'b0; rotateN90_press = 1'b0;
    ticks(4);
    checks++;
    if (heading !== 2'd0 || n_turned - base_t !== 0) begin
      errors++;
      $display("FAIL dual_turn: head=%0d pulses=%0d, expected head=0 pulses=0",
               heading, n_turned - base_t);
    end
  endtask

  task automatic test_busy_and_reset();
    int base_t;
    int base_m;
    turn_once(2);                  // N -> E at (1,0); target (2,0)
    base_t = n_turned;
    forward_press = 1'b1;
    ticks(3);
    for (int i = 0; i < 2; i++) begin
      rotate90_press = 1'b1; ticks(3);
      rotate90_press = 1'b0; ticks(3);
    end
    checks++;
    if (map_req !== 1'b1 || map_addr !== 8'd2 || heading !== 2'd1 || n_turned - base_t !== 0) begin
      errors++;
      $display("FAIL busy_hold: req=%b addr=%0d head=%0d turns=%0d, expected 1/2/1/0",
               map_req, map_addr, heading, n_turned - base_t);
    end
    map_ack = 1'b1;
    tick();
    map_ack = 1'b0;
    tick();
    forward_press = 1'b0;
    ticks(4);
    checks++;
    if (pos_x !== 4'd2 || pos_y !== 4'd0 || heading !== 2'd1 || n_turned - base_t !== 0) begin
      errors++;
      $display("FAIL busy_after: pos=(%0d,%0d) head=%0d turns=%0d, expected (2,0) 1 0",
               pos_x, pos_y, heading, n_turned - base_t);
    end
    // Reset in the middle of a query toward (3,0).
    forward_press = 1'b1;
    ticks(4);
    checks++;
    if (map_req !== 1'b1 || map_addr !== 8'd3) begin
      errors++;
      $display("FAIL rst_pre: req=%b addr=%0d, expected 1/3", map_req, map_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (map_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: req=%b busy=%b right after reset, expected 0/0",
               map_req, busy);
    end
    checks++;
    if (pos_x !== 4'd1 || pos_y !== 4'd1 || heading !== 2'd0 || map_addr !== 8'd0) begin
      errors++;
      $display("FAIL rst_vals: pos=(%0d,%0d) head=%0d addr=%0d, expected (1,1) 0 0",
               pos_x, pos_y, heading, map_addr);
    end
    forward_press = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(2);
    base_m = n_moved;
    map_ack = 1'b1;
    tick();
    map_ack = 1'b0;
    ticks(4);
    checks++;
    if (busy !== 1'b0 || map_req !== 1'b0 || n_moved - base_m !== 0 ||
        pos_x !== 4'd1 || pos_y !== 4'd1) begin
      errors++;
      $display("FAIL stray_ack: busy=%b req=%b moves=%0d pos=(%0d,%0d), expected 0 0 0 (1,1)",
               busy, map_req, n_moved - base_m, pos_x, pos_y);
    end
  endtask

  initial begin
    test_reset();
    test_turn();
    test_move_free();
    test_move_wall();
    test_oob_and_dual_turn();
    test_busy_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
